// File: rtl/axi_reg_master_arb.sv
// rtl/axi_reg_master_arb.sv - two-requester round-robin arbiter driving a single-beat AXI register master
module axi_reg_master_arb #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [63:0] addr_i,
    input  logic [63:0] wdata_i,
    output logic [1:0]  done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] awaddr_o,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wstrb_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    input  logic [1:0]  bresp_i,
    input  logic        bvalid_i,
    output logic        bready_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;

    state_t          state;
    logic            prio;
    logic            gnt;
    logic            aw_done;
    logic            w_done;
    logic [TW-1:0]   timer;

    logic            gnt_next;
    logic            sel_we;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [1:0]      done_sel;
    logic            last_wait;
    logic            aw_hs;
    logic            w_hs;

    // prio names the requester that wins a tie: the one not served last
    always_comb begin
        gnt_next  = (req_i == 2'b11) ? prio : req_i[1];
        sel_we    = gnt_next ? we_i[1] : we_i[0];
        sel_addr  = gnt_next ? addr_i[63:32] : addr_i[31:0];
        sel_wdata = gnt_next ? wdata_i[63:32] : wdata_i[31:0];
        done_sel  = gnt ? 2'b10 : 2'b01;
        last_wait = (timer == TW'(TIMEOUT - 1));
        aw_hs     = awvalid_o & awready_i;
        w_hs      = wvalid_o & wready_i;
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state     <= IDLE;
            prio      <= 1'b0;
            gnt       <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            timer     <= '0;
            done_o    <= 2'b00;
            err_o     <= 1'b0;
            rdata_o   <= 32'h0;
            awaddr_o  <= 32'h0;
            awvalid_o <= 1'b0;
            wdata_o   <= 32'h0;
            wstrb_o   <= 4'h0;
            wvalid_o  <= 1'b0;
            bready_o  <= 1'b0;
            araddr_o  <= 32'h0;
            arvalid_o <= 1'b0;
            rready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_i) begin
                        gnt     <= gnt_next;
                        prio    <= ~gnt_next;
                        timer   <= '0;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (sel_we) begin
                            awaddr_o  <= sel_addr;
                            wdata_o   <= sel_wdata;
                            wstrb_o   <= 4'hF;
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                            state     <= WADDR;
                        end else begin
                            araddr_o  <= sel_addr;
                            arvalid_o <= 1'b1;
                            state     <= RADDR;
                        end
                    end
                end
                WADDR: begin
                    if (aw_hs) begin
                        awvalid_o <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid_o <= 1'b0;
                        w_done   <= 1'b1;
                    end
                    if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                        bready_o <= 1'b1;
                        timer    <= '0;
                        state    <= WRESP;
                    end else if (last_wait) begin
                        awvalid_o <= 1'b0;
                        wvalid_o  <= 1'b0;
                        done_o    <= done_sel;
                        err_o     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WRESP: begin
                    if (bvalid_i) begin
                        bready_o <= 1'b0;
                        done_o   <= done_sel;
                        err_o    <= (bresp_i != 2'b00);
                        state    <= DONE;
                    end else if (last_wait) begin
                        bready_o <= 1'b0;
                        done_o   <= done_sel;
                        err_o    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RADDR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                        timer     <= '0;
                        state     <= RDATA;
                    end else if (last_wait) begin
                        arvalid_o <= 1'b0;
                        done_o    <= done_sel;
                        err_o     <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                RDATA: begin
                    if (rvalid_i) begin
                        rready_o <= 1'b0;
                        rdata_o  <= rdata_i;
                        done_o   <= done_sel;
                        err_o    <= (rresp_i != 2'b00);
                        state    <= DONE;
                    end else if (last_wait) begin
                        rready_o <= 1'b0;
                        done_o   <= done_sel;
                        err_o    <= 1'b1;
                        state    <= DONE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DONE: begin
                    done_o <= 2'b00;
                    err_o  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_reg_master_arb.sv
// tb/tb_axi_reg_master_arb.sv - randomized bench for axi_reg_master_arb against a transaction-level model
module tb_axi_reg_master_arb;

    localparam int TMO = 64;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  we_i = 2'b00;
    logic [63:0] addr_i = 64'h0;
    logic [63:0] wdata_i = 64'h0;
    logic [1:0]  done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] awaddr_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wvalid_o;
    logic        wready_i;
    logic [1:0]  bresp_i;
    logic        bvalid_i;
    logic        bready_o;
    logic [31:0] araddr_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i;
    logic        rready_o;

    axi_reg_master_arb #(.TIMEOUT(TMO)) dut (
        .clk(clk), .areset(areset), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave configuration and observations
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_c = 2'b00, rresp_c = 2'b00;
    logic [31:0] rdata_c = 32'h0;
    logic [31:0] seen_awaddr = 32'h0, seen_wdata = 32'h0, seen_araddr = 32'h0;
    logic [3:0]  seen_wstrb = 4'h0;
    int          w_only_cnt = 0, ar_hi_cnt = 0;

    // reference model state
    logic        favor = 1'b0;
    logic [31:0] model_rdata = 32'h0;

    initial begin
        int aw_c, w_c, b_c, ar_c, r_c;
        aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
        arready_i = 1'b0; rvalid_i = 1'b0; rresp_i = 2'b00; rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            aw_c = awvalid_o ? aw_c + 1 : 0;
            awready_i = awvalid_o && (aw_c > aw_dly);
            if (awready_i) seen_awaddr = awaddr_o;
            w_c = wvalid_o ? w_c + 1 : 0;
            wready_i = wvalid_o && (w_c > w_dly);
            if (wready_i) begin
                seen_wdata = wdata_o;
                seen_wstrb = wstrb_o;
            end
            ar_c = arvalid_o ? ar_c + 1 : 0;
            arready_i = arvalid_o && (ar_c > ar_dly);
            if (arready_i) seen_araddr = araddr_o;
            if (arvalid_o) ar_hi_cnt++;
            b_c = bready_o ? b_c + 1 : 0;
            bvalid_i = bready_o && (b_c > b_dly);
            bresp_i = bvalid_i ? bresp_c : 2'b00;
            r_c = rready_o ? r_c + 1 : 0;
            rvalid_i = rready_o && (r_c > r_dly);
            rdata_i = rvalid_i ? rdata_c : 32'h0;
            rresp_i = rvalid_i ? rresp_c : 2'b00;
            if (awvalid_o && !wvalid_o) w_only_cnt++;
        end
    end

    function automatic logic [1:0] pick(input int f);
        if (f >= 0) return f[1:0];
        return ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    endfunction

    task automatic wait_done();
        int k;
        k = 0;
        while (done_o == 2'b00 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(|done_o), 64'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o, done_o, err_o, wstrb_o}, 0);
        check({tag, "_awaddr"}, awaddr_o, 0);
        check({tag, "_araddr"}, araddr_o, 0);
        check({tag, "_wdata"}, wdata_o, 0);
        check({tag, "_rdata"}, rdata_o, 0);
    endtask

    // Called at a negedge with the DUT idle; serves every requester in mask.
    task automatic serve(input logic [1:0] mask, input logic [1:0] we, input logic [63:0] addr,
                         input logic [63:0] wd, input int rforce);
        logic [1:0] pend;
        int g;
        pend = mask;
        we_i = we;
        addr_i = addr;
        wdata_i = wd;
        while (pend != 2'b00) begin
            g = (pend == 2'b11) ? int'(favor) : (pend[1] ? 1 : 0);
            favor = (g == 0);
            rdata_c = $urandom;
            bresp_c = pick(rforce);
            rresp_c = pick(rforce);
            req_i = pend;
            wait_done();
            check("done_who", done_o, (g == 0) ? 2'b01 : 2'b10);
            check("err", err_o, we[g] ? (bresp_c != 2'b00) : (rresp_c != 2'b00));
            if (we[g]) begin
                check("awaddr", seen_awaddr, addr[32*g +: 32]);
                check("wdata", seen_wdata, wd[32*g +: 32]);
                check("wstrb", seen_wstrb, 4'hF);
                check("rdata_hold", rdata_o, model_rdata);
            end else begin
                check("araddr", seen_araddr, addr[32*g +: 32]);
                check("rdata", rdata_o, rdata_c);
                model_rdata = rdata_c;
            end
            pend[g] = 1'b0;
            req_i = pend;
            @(negedge clk);
            check("done_pulse", done_o, 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        areset = 1'b1;
        @(negedge clk);

        // simultaneous reads after reset: requester 0 first
        serve(2'b11, 2'b00, {32'h3, 32'h2}, 64'h0, 0);

        serve(2'b01, 2'b01, {32'h0, 32'h1}, {32'h0, 32'hC2CCEE2E}, 0);

        // wready three cycles ahead of awready
        aw_dly = 3; w_dly = 0;
        w_only_cnt = 0;
        serve(2'b01, 2'b01, {32'h0, 32'h10}, {32'h0, 32'h12345678}, 0);
        check("w_first_cycles", w_only_cnt, 3);
        aw_dly = 0;

        serve(2'b10, 2'b00, {32'h44, 32'h0}, 64'h0, 2);

        // read address never accepted
        ar_dly = 1000;
        ar_hi_cnt = 0;
        we_i = 2'b00;
        addr_i = {32'h0, 32'h40};
        req_i = 2'b01;
        favor = 1'b1;
        wait_done();
        check("tmo_who", done_o, 2'b01);
        check("tmo_err", err_o, 1);
        check("tmo_arvalid", arvalid_o, 0);
        check("tmo_cycles", ar_hi_cnt, TMO);
        req_i = 2'b00;
        @(negedge clk);
        check("tmo_pulse", done_o, 0);
        ar_dly = 0;

        // reset while waiting for the write response
        b_dly = 1000;
        we_i = 2'b01;
        addr_i = {32'h0, 32'h80};
        wdata_i = {32'h0, 32'hA5A5A5A5};
        req_i = 2'b01;
        for (int k = 0; k < 100 && !bready_o; k++) @(negedge clk);
        check("wresp_reached", bready_o, 1);
        areset = 1'b0;
        #1;
        check_all_zero("midreset");
        req_i = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("midreset_nodone", done_o, 0);
        end
        areset = 1'b1;
        favor = 1'b0;
        model_rdata = 32'h0;
        b_dly = 0;
        @(negedge clk);
        serve(2'b10, 2'b10, {$urandom, $urandom}, {$urandom, $urandom}, 0);
        serve(2'b11, 2'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, -1);

        for (int i = 0; i < 40; i++) begin
            aw_dly = $urandom_range(0, 4);
            w_dly  = $urandom_range(0, 4);
            b_dly  = $urandom_range(0, 4);
            ar_dly = $urandom_range(0, 4);
            r_dly  = $urandom_range(0, 4);
            serve(2'($urandom_range(1, 3)), 2'($urandom), {$urandom, $urandom},
                  {$urandom, $urandom}, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
